// File: rtl/adt7420_poll_ctrl.sv
// Autonomous ADT7420 sequencer: one config write after reset, then periodic 16-bit temperature
// reads through an I2C master. Build macro I2C_RETRY_EN enables per-transaction retries.
module adt7420_poll_ctrl #(
   parameter logic [6:0]  SLAVE_ADDR    = 7'h4B,
   parameter logic [7:0]  CFG_VALUE     = 8'h80,
   parameter int unsigned PERIOD_CYCLES = 25_000_000,
   parameter int unsigned START_TIMEOUT = 16,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic        i_clk,
   input  logic        reset_n,
   input  logic        i_enable,
   output logic        m_req_trans,
   output logic [7:0]  m_addr_w_rw,
   output logic [15:0] m_sub_addr,
   output logic        m_sub_len,
   output logic [23:0] m_byte_len,
   output logic [7:0]  m_data_write,
   input  logic        m_req_data_chunk,
   input  logic [7:0]  m_data_out,
   input  logic        m_valid_out,
   input  logic        m_busy,
   input  logic        m_nack,
   output logic [15:0] o_temp,
   output logic        o_temp_valid,
   output logic        o_err,
   output logic [7:0]  o_err_cnt,
   output logic        o_cfg_done,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CFG_REQ = 3'd1,
      RD_REQ  = 3'd2,
      START   = 3'd3,
      XFER    = 3'd4,
      WAIT    = 3'd5
   } state_t;

   localparam int unsigned PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int unsigned TO_W  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);

   logic unused_inputs;
`ifdef I2C_RETRY_EN
   localparam int unsigned RETRY_LIMIT = MAX_RETRIES;
   assign unused_inputs = m_req_data_chunk;
`else
   // Retries disabled: a zero limit makes every failure final.
   localparam int unsigned RETRY_LIMIT = 0;
   assign unused_inputs = m_req_data_chunk ^ (MAX_RETRIES == 0);
`endif
   localparam int unsigned RC_W = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RETRY_LIMIT);

   state_t            state_q, state_d;
   logic [PER_W-1:0]  wait_q, wait_d;
   logic [TO_W-1:0]   to_q, to_d;
   logic [RC_W-1:0]   retry_q, retry_d;
   logic              nack_q, nack_d;
   logic [1:0]        idx_q, idx_d;
   logic [7:0]        msb_q, msb_d, lsb_q, lsb_d;
   logic              rd_q, rd_d;
   logic              fail;
   logic              can_retry;

   logic              req_d;
   logic [7:0]        addr_d;
   logic [15:0]       sub_d;
   logic [23:0]       len_d;
   logic [7:0]        data_d;
   logic [15:0]       temp_d;
   logic              temp_valid_d, err_d, cfg_done_d;
   logic [7:0]        err_cnt_d;

   assign can_retry = (retry_q != RC_LAST);
   assign m_sub_len = 1'b0;
   assign dbg_state = state_q;

   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      to_d         = to_q;
      retry_d      = retry_q;
      nack_d       = nack_q;
      idx_d        = idx_q;
      msb_d        = msb_q;
      lsb_d        = lsb_q;
      rd_d         = rd_q;
      fail         = 1'b0;
      req_d        = 1'b0;
      addr_d       = m_addr_w_rw;
      sub_d        = m_sub_addr;
      len_d        = m_byte_len;
      data_d       = m_data_write;
      temp_d       = o_temp;
      temp_valid_d = 1'b0;
      err_d        = 1'b0;
      err_cnt_d    = o_err_cnt;
      cfg_done_d   = o_cfg_done;

      case (state_q)
         IDLE: begin
            if (i_enable) begin
               retry_d = '0;
               state_d = o_cfg_done ? RD_REQ : CFG_REQ;
            end
         end
         CFG_REQ, RD_REQ: state_d = START;
         START: begin
            nack_d = nack_q | m_nack;
            if (m_busy) begin
               state_d = XFER;
            end else if (to_q == TO_LAST) begin
               fail = 1'b1;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         XFER: begin
            nack_d = nack_q | m_nack;
            if (rd_q && m_valid_out) begin
               if (idx_q == 2'd0) begin
                  msb_d = m_data_out;
                  idx_d = 2'd1;
               end else if (idx_q == 2'd1) begin
                  lsb_d = m_data_out;
                  idx_d = 2'd2;
               end
            end
            // A byte arriving with the busy fall has already been counted in idx_d.
            if (!m_busy) begin
               if (nack_d || (rd_q && idx_d != 2'd2)) begin
                  fail = 1'b1;
               end else begin
                  retry_d = '0;
                  wait_d  = '0;
                  state_d = WAIT;
                  if (rd_q) begin
                     temp_d       = {msb_d, lsb_d};
                     temp_valid_d = 1'b1;
                  end else begin
                     cfg_done_d = 1'b1;
                  end
               end
            end
         end
         WAIT: begin
            if (!i_enable) begin
               state_d = IDLE;
            end else if (wait_q == PER_LAST) begin
               wait_d  = '0;
               retry_d = '0;
               state_d = o_cfg_done ? RD_REQ : CFG_REQ;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (fail) begin
         if (can_retry) begin
            retry_d = retry_q + 1'b1;
            state_d = rd_q ? RD_REQ : CFG_REQ;
         end else begin
            retry_d = '0;
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = WAIT;
            if (o_err_cnt != 8'hFF) err_cnt_d = o_err_cnt + 8'd1;
         end
      end

      // Request fields are loaded on entry and then held until the next request.
      if (state_d == CFG_REQ || state_d == RD_REQ) begin
         req_d  = 1'b1;
         rd_d   = (state_d == RD_REQ);
         addr_d = {SLAVE_ADDR, (state_d == RD_REQ)};
         sub_d  = (state_d == RD_REQ) ? 16'h0000 : 16'h0003;
         len_d  = (state_d == RD_REQ) ? 24'd2 : 24'd1;
         data_d = CFG_VALUE;
         nack_d = 1'b0;
         idx_d  = 2'd0;
         to_d   = '0;
      end
   end

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         wait_q       <= '0;
         to_q         <= '0;
         retry_q      <= '0;
         nack_q       <= 1'b0;
         idx_q        <= 2'd0;
         msb_q        <= 8'd0;
         lsb_q        <= 8'd0;
         rd_q         <= 1'b0;
         m_req_trans  <= 1'b0;
         m_addr_w_rw  <= 8'd0;
         m_sub_addr   <= 16'd0;
         m_byte_len   <= 24'd0;
         m_data_write <= 8'd0;
         o_temp       <= 16'd0;
         o_temp_valid <= 1'b0;
         o_err        <= 1'b0;
         o_err_cnt    <= 8'd0;
         o_cfg_done   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         to_q         <= to_d;
         retry_q      <= retry_d;
         nack_q       <= nack_d;
         idx_q        <= idx_d;
         msb_q        <= msb_d;
         lsb_q        <= lsb_d;
         rd_q         <= rd_d;
         m_req_trans  <= req_d;
         m_addr_w_rw  <= addr_d;
         m_sub_addr   <= sub_d;
         m_byte_len   <= len_d;
         m_data_write <= data_d;
         o_temp       <= temp_d;
         o_temp_valid <= temp_valid_d;
         o_err        <= err_d;
         o_err_cnt    <= err_cnt_d;
         o_cfg_done   <= cfg_done_d;
      end
   end

endmodule

// File: doc/adt7420_poll_ctrl.md
# adt7420_poll_ctrl

Sequencer that drives the I2C master to run an ADT7420 temperature sensor on its own. After reset it writes the sensor configuration register once. It then reads the 16-bit temperature register periodically and presents each result as a registered word with a one-cycle valid strobe. It sits between the I2C master's request/handshake ports and the user logic, so nothing else has to issue raw I2C transactions.

## Interface
- SLAVE_ADDR, 7'h4B: 7-bit sensor address.
- CFG_VALUE, 8'h80: byte written to sub-address 0x03 (16-bit resolution, continuous conversion).
- PERIOD_CYCLES, 25_000_000: i_clk cycles between the end of one read and the next request; minimum 1.
- START_TIMEOUT, 16: cycles allowed after a request for m_busy to rise.
- MAX_RETRIES, 3: NACK retries per transaction (only with I2C_RETRY_EN).

Ports:
- i_clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  run polling; sampled only in WAIT and IDLE.
- m_req_trans  out  1  one-cycle transaction request to the master.
- m_addr_w_rw  out  8  {SLAVE_ADDR, rw}.
- m_sub_addr  out  16  register pointer; upper byte is always 0.
- m_sub_len  out  1  always 0 (8-bit sub-address).
- m_byte_len  out  24  1 for the config write, 2 for the temperature read.
- m_data_write  out  8  CFG_VALUE.
- m_req_data_chunk  in  1  master wants the next write byte; tolerated and ignored.
- m_data_out  in  8  read byte.
- m_valid_out  in  1  m_data_out valid.
- m_busy  in  1  master transaction active.
- m_nack  in  1  slave NACK.
- o_temp  out  16  last good reading, MSB first.
- o_temp_valid  out  1  one-cycle strobe when o_temp updates.
- o_err  out  1  one-cycle strobe when a transaction is abandoned.
- o_err_cnt  out  8  saturating count of o_err pulses.
- o_cfg_done  out  1  sticky; set when the config write succeeds.

## Operation
States: IDLE, CFG_REQ, RD_REQ, START, XFER, WAIT.
- **IDLE**
  - Entered from reset.
  - If i_enable=1: go to RD_REQ when o_cfg_done=1, otherwise CFG_REQ.
- **CFG_REQ**
  - Assert m_req_trans for exactly one cycle with m_addr_w_rw={SLAVE_ADDR,0}, m_sub_addr=16'h0003, m_byte_len=1.
  - Go to START.
- **RD_REQ**
  - Assert m_req_trans for one cycle with m_addr_w_rw={SLAVE_ADDR,1}, m_sub_addr=16'h0000, m_byte_len=2.
  - Clear the byte index; go to START.
- **START**
  - Wait for m_busy=1, then go to XFER.
  - If START_TIMEOUT cycles pass without m_busy rising, the transaction fails.
- **XFER**
  - Latch m_nack=1 into a sticky flag.
  - During a read: the first m_valid_out loads the temp MSB shadow, the second loads the LSB shadow; further strobes are ignored.
  - On the m_busy falling edge:
    - Failure if the NACK flag is set, or a read captured fewer than 2 bytes.
    - Otherwise success: a write sets o_cfg_done; a read copies the shadow to o_temp and pulses o_temp_valid.
  - Either way, go to WAIT (success or exhausted failure) or back to the request state (retry).
- **WAIT**
  - Count PERIOD_CYCLES.
  - If i_enable=0 at any point, go to IDLE.
  - At terminal count, go to RD_REQ, or to CFG_REQ if o_cfg_done=0.
- **Failure**: pulse o_err and increment o_err_cnt, which saturates at 255.
- **i_enable dropped mid-transaction**: the transaction completes normally; the state machine reaches WAIT and then drops to IDLE.

## Timing
- **Reset value of every output:** 0 (including o_temp, o_err_cnt and o_cfg_done).
- Request outputs other than m_req_trans are registered and held stable from the request cycle until m_busy falls.
- **Latency:**
  - o_temp_valid is asserted on the cycle after the m_busy falling edge is sampled.
  - IDLE to m_req_trans takes 1 cycle after i_enable is sampled high.
- A read result and an error cannot occur on the same cycle.
- m_valid_out arriving in the same cycle as the m_busy fall is captured before the byte-count check.
- **Reset during XFER:** everything returns to reset values at once, with no wait for the master. The master is reset by the same reset_n.
- The period counter is wide enough for PERIOD_CYCLES, rounded up with clog2, and wraps to 0 on reload.

## Configuration
- **I2C_RETRY_EN defined:**
  - A failed transaction reissues the same request, going back to CFG_REQ or RD_REQ directly with no period wait.
  - Up to MAX_RETRIES times, counted per transaction; the retry counter clears on success or on a fresh request from WAIT.
  - o_err pulses only after the final retry fails.
- **I2C_RETRY_EN undefined:**
  - The first failure pulses o_err and goes to WAIT.
  - MAX_RETRIES is unused.

## Test plan
- Release reset with i_enable=1 and the slave model ACKing -> one write request {0x96, sub 0x03, len 1, data 0x80}, then o_cfg_done=1, then after PERIOD_CYCLES a read request {0x97, sub 0x00, len 2}.
- Slave returns 0x0C, 0x80 -> o_temp=16'h0C80, with o_temp_valid high for one cycle after m_busy falls.
- Slave NACKs the address on every attempt -> with I2C_RETRY_EN: 4 requests, 1 o_err pulse, o_err_cnt=1. Without it: 1 request, 1 o_err pulse.
- m_busy never rises after a request -> o_err after 16 cycles; the state machine enters WAIT.
- Read returns only 1 valid byte before m_busy falls -> o_err pulses and o_temp is unchanged.
- Assert reset_n=0 mid-XFER, then drop i_enable during WAIT -> all outputs are 0 immediately; with i_enable=0 no further m_req_trans is issued.
